mem_1r1w_masked_banked: RTL
===========================

Name: mem_1r1w_masked_banked

Overview:
- Parametrised single-clock 1R1W memory with a byte/granule write mask, built from 2^k-deep banks.
- Bank select uses the upper address bits. The bank index is registered to steer read data.
- Adds behaviour not present in earlier fixed-size wrappers:
  - true per-granule masking
  - write-first read/write collision forwarding
  - read-valid handshake
  - out-of-range address protection with a sticky error flag
- Sits between core-side SRAM requesters and the per-bank macro models.

Parameters:
- DEPTH, 48, total words; need not be a multiple of BANK_DEPTH.
- WIDTH, 64, data bits per word.
- MASK_GRAN, 8, bits per mask lane; WIDTH % MASK_GRAN == 0.
- BANK_DEPTH, 32, words per bank; power of two.
- Derived: NBANKS = ceil(DEPTH/BANK_DEPTH); AW = clog2(DEPTH); BW = clog2(BANK_DEPTH); MW = WIDTH/MASK_GRAN.

Ports:
- clk  in  1  single clock for both ports.
- rst_n  in  1  asynchronous, active-low reset.
- R0_addr  in  AW  read word address.
- R0_en  in  1  read request.
- R0_data  out  WIDTH  read data, valid when R0_valid=1.
- R0_valid  out  1  read data valid strobe.
- W0_addr  in  AW  write word address.
- W0_en  in  1  write request.
- W0_data  in  WIDTH  write data.
- W0_mask  in  MW  per-lane write enable; bit i covers data[i*MASK_GRAN +: MASK_GRAN].
- err_oob  out  1  sticky flag: a request used addr >= DEPTH.
- err_clr  in  1  synchronous clear of err_oob.

Behaviour:
- Reset (rst_n=0, async assert, sync deassert assumed upstream):
  - R0_valid=0, R0_data=0, err_oob=0.
  - Bank-index register, collision register and forwarding mask/data registers cleared.
  - Array contents are not reset (undefined until written).
- Bank select: bank = addr >> BW; in-bank offset = addr[BW-1:0].
  - Only the selected bank is enabled per port.
  - Enable for an address in the last partial bank above DEPTH-1 is suppressed.
- Write:
  - W0_en=1, addr < DEPTH: lanes with mask=1 are written at the rising edge; lanes with mask=0 keep their old value.
  - mask=0 in all lanes: no state change.
- Read:
  - R0_en=1, addr < DEPTH: data and R0_valid=1 appear the cycle after the request (latency 1).
  - R0_valid is a single-cycle pulse per accepted read. A read every cycle gives back-to-back valids.
  - R0_data holds its last value when R0_valid=0.
- Out of range (addr >= DEPTH):
  - Write is dropped.
  - Read still produces R0_valid=1 with R0_data=0.
  - err_oob sets the next cycle.
  - If err_clr and a new OOB event occur in the same cycle, set wins.
- Collision (R0_en and W0_en, same in-range address, same cycle):
  - Write-first: returned word = W0_data on masked lanes, old array data on unmasked lanes.
  - Implementation: register the collision flag, mask and data, then merge at the output mux. The array read is not trusted on collision.
- Read and write to different banks, or different addresses in the same bank: fully independent, no stall.
- Reset asserted mid-read: the pending R0_valid is dropped. There is no output after reset release until a new R0_en.

Optional Feature:
- Macro: MEM_OUT_REG_EN.
- Defined: adds an output pipeline register after the bank mux and collision merge.
  - Read latency becomes 2; R0_valid is delayed accordingly.
  - The register is reset to 0/invalid.
  - Collision semantics are unchanged and refer to the request cycle. A write in the cycle after a read does not affect that read's data.
- Undefined: latency 1 as above.

Decomposition:
- Package mem_lower_pkg holds:
  - clog2 / ceil-div helper functions.
  - Constant MEM_RD_LAT_BASE=1.
  - Typedef of the mask-expansion helper (mask lane to bit vector).
- Sub-module mem_bank:
  - One BANK_DEPTH x WIDTH array, per-lane write enable, registered read, chip enables.
  - Instantiated NBANKS times with a generate loop.
  - The top holds bank decode, index register, collision/forward logic, valid and error logic.

Test Plan:
- Reset then idle: rst_n low 3 cycles → R0_valid=0, R0_data=0, err_oob=0; rst_n high, no requests → outputs unchanged.
- Masked write/read in bank 1:
  - write addr 40 data 0x1122334455667788 mask 0xFF, then write same addr data 0xAAAAAAAAAAAAAAAA mask 0x0F.
  - read addr 40 → R0_data=0x11223344AAAAAAAA one cycle later, R0_valid pulse of 1 cycle.
- Bank boundary: write addr 31 = 0x31, addr 32 = 0x32, then read 31 and 32 on consecutive cycles → data 0x31, 0x32 on back-to-back valid cycles.
- Collision:
  - preload addr 5 = 0x0, then same cycle write addr 5 data 0xFFFFFFFFFFFFFFFF mask 0x81 and read addr 5.
  - → R0_data=0xFF000000000000FF; subsequent read addr 5 returns the same value.
- Out of range:
  - write addr 50 data 0xDEAD → no bank write; read addr 50 → R0_valid=1, R0_data=0; err_oob=1 the next cycle.
  - err_clr pulse → err_oob=0; err_clr concurrent with read addr 63 → err_oob stays 1.
- MEM_OUT_REG_EN build: read addr 40 → R0_valid and data appear 2 cycles after the request; rst_n pulse during that in-flight read → no valid emitted.

Source files
------------

// File: rtl/mem_lower_pkg.sv
// Shared helpers for the banked 1R1W memory: size arithmetic, base read latency
// and the write-mask lane expansion used by the collision forwarding path.
package mem_lower_pkg;

  localparam int MEM_RD_LAT_BASE = 1;

  // Upper bound on WIDTH supported by the mask expansion helper.
  localparam int MASK_VEC_W = 1024;
  typedef logic [MASK_VEC_W-1:0] mask_vec_t;

  function automatic int clog2_f(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Lane i of 'lanes' fills bits [i*gran +: gran] of the result.
  function automatic mask_vec_t expand_mask(input mask_vec_t lanes, input int n_lanes,
                                            input int gran);
    mask_vec_t bits = '0;
    for (int i = 0; i < n_lanes; i++) begin
      for (int j = 0; j < gran; j++) begin
        bits[i*gran + j] = lanes[i];
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One BANK_DEPTH x WIDTH storage bank with per-lane write enables and a
// registered read port; each port acts only when its chip enable is high.
module mem_bank
  import mem_lower_pkg::*;
#(
  parameter int BANK_DEPTH = 32,
  parameter int WIDTH      = 64,
  parameter int MASK_GRAN  = 8,
  localparam int BW        = clog2_f(BANK_DEPTH),
  localparam int MW        = WIDTH / MASK_GRAN
) (
  input  logic             clk,
  input  logic             rd_ce,
  input  logic [BW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_ce,
  input  logic [BW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [MW-1:0]    wr_mask
);

  logic [WIDTH-1:0] mem [BANK_DEPTH];

  // NOTE: the array has no reset so it maps onto SRAM macros; the read happens
  // with <= so a same-edge write is not yet visible and the old word comes back.
  always_ff @(posedge clk) begin
    if (wr_ce) begin
      for (int i = 0; i < MW; i++) begin
        if (wr_mask[i]) mem[wr_addr][i*MASK_GRAN +: MASK_GRAN] <= wr_data[i*MASK_GRAN +: MASK_GRAN];
      end
    end
    if (rd_ce) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mem_1r1w_masked_banked.sv
// Banked 1R1W masked memory: bank decode, write-first collision forwarding,
// read-valid strobe and sticky out-of-range flag. Define MEM_OUT_REG_EN for latency 2.
module mem_1r1w_masked_banked
  import mem_lower_pkg::*;
#(
  parameter int DEPTH      = 48,
  parameter int WIDTH      = 64,
  parameter int MASK_GRAN  = 8,
  parameter int BANK_DEPTH = 32,
  localparam int NBANKS    = ceil_div(DEPTH, BANK_DEPTH),
  localparam int AW        = clog2_f(DEPTH),
  localparam int BW        = clog2_f(BANK_DEPTH),
  localparam int MW        = WIDTH / MASK_GRAN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [MW-1:0]    W0_mask,
  output logic             err_oob,
  input  logic             err_clr
);

`ifdef MEM_OUT_REG_EN
  localparam int RD_LAT = MEM_RD_LAT_BASE + 1;
`else
  localparam int RD_LAT = MEM_RD_LAT_BASE;
`endif

  localparam int KW = (AW > BW) ? AW - BW : 1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic             r_range, w_range, r_in, w_in, collide;
  logic [KW-1:0]    r_bank, w_bank;
  logic [BW-1:0]    r_off, w_off;
  logic [WIDTH-1:0] w_bits;
  logic [WIDTH-1:0] bank_rd [NBANKS];

  assign r_range = ({1'b0, R0_addr} < DEPTH_V);
  assign w_range = ({1'b0, W0_addr} < DEPTH_V);
  assign r_in    = R0_en && r_range;
  assign w_in    = W0_en && w_range;
  assign r_bank  = KW'(R0_addr >> BW);
  assign w_bank  = KW'(W0_addr >> BW);
  assign r_off   = BW'(R0_addr);
  assign w_off   = BW'(W0_addr);
  assign collide = r_in && W0_en && (R0_addr == W0_addr);
  assign w_bits  = WIDTH'(expand_mask(mask_vec_t'(W0_mask), MW, MASK_GRAN));

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    mem_bank #(
      .BANK_DEPTH(BANK_DEPTH),
      .WIDTH     (WIDTH),
      .MASK_GRAN (MASK_GRAN)
    ) u_bank (
      .clk    (clk),
      .rd_ce  (r_in && (r_bank == KW'(b))),
      .rd_addr(r_off),
      .rd_data(bank_rd[b]),
      .wr_ce  (w_in && (w_bank == KW'(b))),
      .wr_addr(w_off),
      .wr_data(W0_data),
      .wr_mask(W0_mask)
    );
  end

  // Request-cycle state; held between reads so the output mux holds its value.
  logic             rd_vld_q, rd_zero_q, coll_q;
  logic [KW-1:0]    rd_bank_q;
  logic [WIDTH-1:0] fwd_bits_q, fwd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
      rd_bank_q  <= '0;
      coll_q     <= 1'b0;
      fwd_bits_q <= '0;
      fwd_data_q <= '0;
    end else begin
      rd_vld_q <= R0_en;
      if (R0_en) begin
        rd_zero_q  <= !r_range;
        rd_bank_q  <= r_bank;
        coll_q     <= collide;
        fwd_bits_q <= w_bits;
        fwd_data_q <= W0_data;
      end
    end
  end

  logic [WIDTH-1:0] rd_word;

  // NOTE: rd_word gets a default before any branch so no latch is inferred.
  always_comb begin
    rd_word = '0;
    if (!rd_zero_q) begin
      for (int b = 0; b < NBANKS; b++) begin
        if (rd_bank_q == KW'(b)) rd_word = bank_rd[b];
      end
      if (coll_q) rd_word = (fwd_bits_q & fwd_data_q) | (~fwd_bits_q & rd_word);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_oob <= 1'b0;
    end else if ((R0_en && !r_range) || (W0_en && !w_range)) begin
      err_oob <= 1'b1;
    end else if (err_clr) begin
      err_oob <= 1'b0;
    end
  end

  if (RD_LAT > MEM_RD_LAT_BASE) begin : g_out_reg
    logic [WIDTH-1:0] out_data_q;
    logic             out_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_vld_q <= rd_vld_q;
        if (rd_vld_q) out_data_q <= rd_word;
      end
    end

    assign R0_valid = out_vld_q;
    assign R0_data  = out_data_q;
  end else begin : g_comb_out
    assign R0_valid = rd_vld_q;
    assign R0_data  = rd_word;
  end

endmodule
